// File: rtl/wptr_level_handler.sv
`default_nettype none
// ============================================================================
// wptr_level_handler : write-domain pointers, fill level and status for an
//                      asynchronous FIFO (Gray read pointer decoded locally).
// Revision: 1.0
// ============================================================================
module wptr_level_handler #(
    parameter int PTR_WIDTH   = 3,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 w_en,
    input  logic [PTR_WIDTH:0]   g_rptr_sync,
    input  logic                 clr_ovf,
    output logic [PTR_WIDTH:0]   b_wptr,
    output logic [PTR_WIDTH:0]   g_wptr,
    output logic [PTR_WIDTH-1:0] waddr,
    output logic                 w_ack,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   wlevel,
    output logic                 overflow
);

    localparam logic [PTR_WIDTH:0] c_DEPTH = {1'b1, {PTR_WIDTH{1'b0}}};
    localparam logic [PTR_WIDTH:0] c_AFULL = (PTR_WIDTH+1)'(AFULL_LEVEL);

    logic [PTR_WIDTH:0] b_wptr_q, b_wptr_d;
    logic [PTR_WIDTH:0] g_wptr_q, g_wptr_d;
    logic [PTR_WIDTH:0] wlevel_q, level_d;
    logic [PTR_WIDTH:0] rptr_bin;
    logic               full_q, full_d;
    logic               afull_q, afull_d;
    logic               w_ack_q;
    logic               ovf_q, ovf_d;
    logic               push;

    assign push = w_en & ~full_q;

    always_comb begin
        rptr_bin            = '0;
        rptr_bin[PTR_WIDTH] = g_rptr_sync[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            rptr_bin[i] = rptr_bin[i+1] ^ g_rptr_sync[i];
        end
    end

    // Level uses the stale read pointer, so it can only overstate the fill.
    always_comb begin
        b_wptr_d = b_wptr_q + {{PTR_WIDTH{1'b0}}, push};
        g_wptr_d = (b_wptr_d >> 1) ^ b_wptr_d;
        level_d  = b_wptr_d - rptr_bin;
        full_d   = (level_d == c_DEPTH);
        afull_d  = (level_d >= c_AFULL);
        ovf_d    = ovf_q;
        if (w_en && full_q) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            b_wptr_q <= '0;
            g_wptr_q <= '0;
            wlevel_q <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            w_ack_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            b_wptr_q <= b_wptr_d;
            g_wptr_q <= g_wptr_d;
            wlevel_q <= level_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            w_ack_q  <= push;
            ovf_q    <= ovf_d;
        end
    end

    assign b_wptr      = b_wptr_q;
    assign g_wptr      = g_wptr_q;
    assign waddr       = b_wptr_q[PTR_WIDTH-1:0];
    assign w_ack       = w_ack_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign wlevel      = wlevel_q;
    assign overflow    = ovf_q;

endmodule
`default_nettype wire
